if_fetch_req_ctrl: RTL

Sequences instruction-bus read requests for the IF stage, between the first fetch stage (address source) and the second-stage trace register (data consumer).
Issues one request at a time on the instruction SRAM-like bus (req/addr_ok/data_ok) and bounds the number of outstanding reads.
On a pipeline cancel (branch-check mismatch, exception, or branch-recovery flush), marks every in-flight read as doomed and swallows its returning data_ok, so stale instructions never reach the downstream stage.

---
 rtl/if_fetch_req_ctrl_if.sv | 31 +++
 rtl/if_fetch_req_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_req_ctrl_if.sv
// rtl/if_fetch_req_ctrl_if.sv - instruction SRAM-like bus between IF request controller and memory
//
// Purpose : groups the instruction-side read bus (req/addr_ok/data_ok) into one bundle.
// Signals : inst_req_o     - bus request, driven by the fetch controller
//           inst_addr_o    - bus address, held stable while inst_req_o is high
//           inst_addr_ok_i - bus accepted the address this cycle
//           inst_data_ok_i - bus returned read data this cycle
// Modports: master - fetch controller side; slave - memory/bus side.

interface if_fetch_req_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              inst_req_o;
   logic [ADDR_W-1:0] inst_addr_o;
   logic              inst_addr_ok_i;
   logic              inst_data_ok_i;

   modport master (
      output inst_req_o,
      output inst_addr_o,
      input  inst_addr_ok_i,
      input  inst_data_ok_i
   );

   modport slave (
      input  inst_req_o,
      input  inst_addr_o,
      output inst_addr_ok_i,
      output inst_data_ok_i
   );
endinterface

// File: rtl/if_fetch_req_ctrl.sv
// rtl/if_fetch_req_ctrl.sv - IF-stage instruction read request sequencer with cancel/discard tracking
//
// Purpose : issues one instruction read at a time on the SRAM-like bus, bounds the number
//           of accepted-but-unreturned reads, and swallows returns that belong to reads
//           in flight when the pipeline was cancelled.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           fetch_valid_i   - upstream presents a fetch address
//           fetch_addr_i    - fetch address
//           fetch_ready_o   - address accepted this cycle when fetch_valid_i is high
//           cancel_i        - pipeline cancel (branch mismatch / exception / flush)
//           bus             - instruction bus, master side
//           resp_valid_o    - returned data is live, forward downstream
//           outstanding_o   - reads accepted by the bus and not yet returned
//           discard_o       - returns still to be swallowed
//           err_o           - sticky protocol error (data_ok with nothing outstanding)

module if_fetch_req_ctrl #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 2,
   parameter int ADDR_W          = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fetch_valid_i,
   input  logic [ADDR_W-1:0]   fetch_addr_i,
   output logic                fetch_ready_o,
   input  logic                cancel_i,
   if_fetch_req_ctrl_if.master bus,
   output logic                resp_valid_o,
   output logic [CNT_W-1:0]    outstanding_o,
   output logic [CNT_W-1:0]    discard_o,
   output logic                err_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_t            state_q;
   state_t            state_d;

   logic [CNT_W-1:0]  out_q;
   logic [CNT_W-1:0]  out_d;
   logic [CNT_W-1:0]  disc_q;
   logic [CNT_W-1:0]  disc_d;
   logic              doomed_q;
   logic              doomed_d;
   logic              err_q;
   logic              err_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

   logic              fetch_ready;
   logic              issue;
   logic              addr_hs;
   logic              data_eff;
   logic              data_spur;
   logic              disc_dec;
   logic              disc_inc;
   logic [CNT_W:0]    out_sum;
   logic [CNT_W:0]    disc_sum;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // A request is never withdrawn: REQ only leaves on addr_ok, even
   // across a cancel. The doomed flag takes care of the stale read.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.inst_addr_ok_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      bus.inst_req_o = (state_q == S_REQ);
      fetch_ready    = (state_q == S_IDLE) && (out_q < MAX_CNT) && !cancel_i;
      issue          = fetch_valid_i && fetch_ready;
   end

   // ------------------------------------------------------------------
   // Counters, doomed flag, error, address latch
   // ------------------------------------------------------------------
   always_comb begin
      addr_hs   = (state_q == S_REQ) && bus.inst_addr_ok_i;
      // A return with nothing outstanding is a protocol error and must
      // not decrement the counter below zero.
      data_eff  = bus.inst_data_ok_i && (out_q != CNT_ZERO);
      data_spur = bus.inst_data_ok_i && (out_q == CNT_ZERO);

      out_sum = {1'b0, out_q} + {CNT_ZERO, addr_hs} - {CNT_ZERO, data_eff};
      if (out_sum > {1'b0, MAX_CNT}) begin
         out_d = MAX_CNT;
      end else begin
         out_d = out_sum[CNT_W-1:0];
      end

      disc_dec = bus.inst_data_ok_i && (disc_q != CNT_ZERO);
      disc_inc = addr_hs && doomed_q;

      if (cancel_i) begin
         // Everything still in flight after this edge, including a read
         // handshaking right now, belongs to the cancelled path.
         disc_sum = {1'b0, out_d};
         doomed_d = (state_q == S_REQ) && !bus.inst_addr_ok_i;
      end else begin
         disc_sum = {1'b0, disc_q} - {CNT_ZERO, disc_dec} + {CNT_ZERO, disc_inc};
         doomed_d = addr_hs ? 1'b0 : doomed_q;
      end

      // Keep discard within the outstanding count so it can never wrap.
      if (disc_sum > {1'b0, out_d}) begin
         disc_d = out_d;
      end else begin
         disc_d = disc_sum[CNT_W-1:0];
      end

      err_d  = err_q || data_spur;
      addr_d = issue ? fetch_addr_i : addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= '0;
         disc_q   <= '0;
         doomed_q <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
      end else begin
         out_q    <= out_d;
         disc_q   <= disc_d;
         doomed_q <= doomed_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
      end
   end

   // ------------------------------------------------------------------
   // Output drive
   // A return is live only if no swallowing is pending. A return in the
   // cancel cycle itself with discard at zero still goes out: it belongs
   // to the pre-cancel window and downstream samples cancel on its own.
   // ------------------------------------------------------------------
   assign bus.inst_addr_o   = addr_q;
   assign fetch_ready_o     = fetch_ready;
   assign resp_valid_o      = bus.inst_data_ok_i && (disc_q == CNT_ZERO) && (out_q != CNT_ZERO);
   assign outstanding_o     = out_q;
   assign discard_o         = disc_q;
   assign err_o             = err_q;

endmodule
